// File: rtl/vmask_pack_seq.sv
// rtl/vmask_pack_seq.sv - mask-reduction pack sequencer feeding the first-set/popcount stage
module vmask_pack_seq #(
   parameter int REQ_DATA_WIDTH  = 64,
   parameter int REQ_ADDR_WIDTH  = 32,
   parameter int IDX_BITS        = 10,
   parameter int DATA_WIDTH_BITS = 6,
   parameter int VL_BITS         = 17,
   parameter int DRAIN_CYCLES    = 6
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [VL_BITS-1:0]        req_vl,
   input  logic                      req_vm,
   input  logic                      req_opSel,
   input  logic [REQ_ADDR_WIDTH-1:0] req_addr,
   input  logic                      src_valid,
   output logic                      src_ready,
   input  logic [REQ_DATA_WIDTH-1:0] src_data,
   input  logic [REQ_DATA_WIDTH-1:0] src_v0,
   output logic                      out_valid,
   output logic [REQ_DATA_WIDTH-1:0] out_m0,
   output logic [IDX_BITS-1:0]       out_start_idx,
   output logic                      out_end,
   output logic [REQ_ADDR_WIDTH-1:0] out_addr,
   output logic                      out_opSel
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_ZERO  = 2'd2;
   localparam logic [1:0] ST_DRAIN = 2'd3;

   localparam int DCW = $clog2(DRAIN_CYCLES + 2);
   localparam logic [DCW-1:0]     DRAIN_MAX = DCW'(DRAIN_CYCLES);
   localparam logic [VL_BITS-1:0] VL_MAX    = VL_BITS'(1) << (IDX_BITS + DATA_WIDTH_BITS);

   logic [1:0]                state_q, state_d;
   logic [IDX_BITS-1:0]       last_idx_q, last_idx_d;
   logic [DATA_WIDTH_BITS-1:0] tail_q, tail_d;
   logic                      vm_q, vm_d;
   logic                      opsel_q, opsel_d;
   logic [REQ_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [IDX_BITS-1:0]       cnt_q, cnt_d;
   logic [DCW-1:0]            drain_q, drain_d;

   logic                      out_valid_q, out_valid_d;
   logic [REQ_DATA_WIDTH-1:0] out_m0_q, out_m0_d;
   logic [IDX_BITS-1:0]       out_idx_q, out_idx_d;
   logic                      out_end_q, out_end_d;
   logic [REQ_ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
   logic                      out_opsel_q, out_opsel_d;

   logic [VL_BITS-1:0]        vl_clamp;
   logic                      handshake;
   logic                      is_last;
   logic [REQ_DATA_WIDTH-1:0] tail_mask;
   logic [REQ_DATA_WIDTH-1:0] v0_mask;

   // Request decode and per-pack masking terms.
   always_comb begin
      vl_clamp  = (req_vl > VL_MAX) ? VL_MAX : req_vl;
      handshake = src_valid && (state_q == ST_ISSUE);
      is_last   = (cnt_q == last_idx_q);
      // Only the final pack is trimmed; a zero tail means vl filled it exactly.
      tail_mask = (is_last && (tail_q != '0)) ? ~({REQ_DATA_WIDTH{1'b1}} << tail_q)
                                              : {REQ_DATA_WIDTH{1'b1}};
      v0_mask   = vm_q ? {REQ_DATA_WIDTH{1'b1}} : src_v0;
   end

   // Next-state logic; output fields default to zero so idle cycles read 0.
   always_comb begin
      state_d     = state_q;
      last_idx_d  = last_idx_q;
      tail_d      = tail_q;
      vm_d        = vm_q;
      opsel_d     = opsel_q;
      addr_d      = addr_q;
      cnt_d       = cnt_q;
      drain_d     = drain_q;
      out_valid_d = 1'b0;
      out_m0_d    = '0;
      out_idx_d   = '0;
      out_end_d   = 1'b0;
      out_addr_d  = '0;
      out_opsel_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               vm_d       = req_vm;
               opsel_d    = req_opSel;
               addr_d     = req_addr;
               last_idx_d = IDX_BITS'((vl_clamp - VL_BITS'(1)) >> DATA_WIDTH_BITS);
               tail_d     = vl_clamp[DATA_WIDTH_BITS-1:0];
               cnt_d      = '0;
               state_d    = (vl_clamp == '0) ? ST_ZERO : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (handshake) begin
               out_valid_d = 1'b1;
               out_m0_d    = src_data & v0_mask & tail_mask;
               out_idx_d   = cnt_q;
               out_end_d   = is_last;
               out_addr_d  = addr_q;
               out_opsel_d = opsel_q;
               cnt_d       = cnt_q + IDX_BITS'(1);
               if (is_last) begin
                  state_d = ST_DRAIN;
                  drain_d = '0;
               end
            end
         end
         ST_ZERO: begin
            out_valid_d = 1'b1;
            out_end_d   = 1'b1;
            out_addr_d  = addr_q;
            out_opsel_d = opsel_q;
            state_d     = ST_DRAIN;
            drain_d     = '0;
         end
         default: begin
            // Hold off new requests until the downstream accumulator pipe is empty.
            if (drain_q == DRAIN_MAX) begin
               state_d = ST_IDLE;
               drain_d = '0;
            end else begin
               drain_d = drain_q + DCW'(1);
            end
         end
      endcase
   end

   // State and output registers; reset abandons any request in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         last_idx_q  <= '0;
         tail_q      <= '0;
         vm_q        <= 1'b0;
         opsel_q     <= 1'b0;
         addr_q      <= '0;
         cnt_q       <= '0;
         drain_q     <= '0;
         out_valid_q <= 1'b0;
         out_m0_q    <= '0;
         out_idx_q   <= '0;
         out_end_q   <= 1'b0;
         out_addr_q  <= '0;
         out_opsel_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_idx_q  <= last_idx_d;
         tail_q      <= tail_d;
         vm_q        <= vm_d;
         opsel_q     <= opsel_d;
         addr_q      <= addr_d;
         cnt_q       <= cnt_d;
         drain_q     <= drain_d;
         out_valid_q <= out_valid_d;
         out_m0_q    <= out_m0_d;
         out_idx_q   <= out_idx_d;
         out_end_q   <= out_end_d;
         out_addr_q  <= out_addr_d;
         out_opsel_q <= out_opsel_d;
      end
   end

   assign req_ready     = (state_q == ST_IDLE);
   assign src_ready     = (state_q == ST_ISSUE);
   assign out_valid     = out_valid_q;
   assign out_m0        = out_m0_q;
   assign out_start_idx = out_idx_q;
   assign out_end       = out_end_q;
   assign out_addr      = out_addr_q;
   assign out_opSel     = out_opsel_q;

endmodule

// File: tb/tb_vmask_pack_seq.sv
// tb/tb_vmask_pack_seq.sv - self-checking bench for vmask_pack_seq
module tb_vmask_pack_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [16:0] req_vl = '0;
   logic        req_vm = 1'b0;
   logic        req_opSel = 1'b0;
   logic [31:0] req_addr = '0;
   logic        src_valid = 1'b0;
   logic        src_ready;
   logic [63:0] src_data = '0;
   logic [63:0] src_v0 = '0;
   logic        out_valid;
   logic [63:0] out_m0;
   logic [9:0]  out_start_idx;
   logic        out_end;
   logic [31:0] out_addr;
   logic        out_opSel;

   vmask_pack_seq dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_vl(req_vl), .req_vm(req_vm),
      .req_opSel(req_opSel), .req_addr(req_addr),
      .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data), .src_v0(src_v0),
      .out_valid(out_valid), .out_m0(out_m0), .out_start_idx(out_start_idx),
      .out_end(out_end), .out_addr(out_addr), .out_opSel(out_opSel)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] m0;
      logic [9:0]  idx;
      logic        e;
      logic [31:0] addr;
      logic        op;
   } pack_t;

   pack_t       exp_q[$];
   logic [63:0] wd[0:7];
   logic [63:0] wv0[0:7];
   int          n_chk = 0;
   int          n_pass = 0;
   int          cyc = 0;
   int          hs_cnt = 0;
   int          sr_cnt = 0;
   logic        hs_prev = 1'b0;
   bit          lag_en = 1'b0;
   int          last_end_cyc = 0;
   logic [63:0] last_m0 = '0;
   logic [9:0]  last_idx = '0;
   logic [31:0] last_addr = '0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", name, act, exp);
   endtask

   // Element-level reference: bit b of pack idx survives if element idx*64+b is below vl
   // and is enabled by v0 (or the request is unmasked).
   function automatic logic [63:0] model_m0(logic [63:0] d, logic [63:0] v0, bit vm, int vl, int idx);
      logic [63:0] r;
      for (int b = 0; b < 64; b++)
         r[b] = d[b] & (vm | v0[b]) & ((idx * 64 + b) < vl);
      return r;
   endfunction

   task automatic push_req(int vl, bit vm, bit op, logic [31:0] addr);
      pack_t p;
      int    v;
      v = (vl > 65536) ? 65536 : vl;
      if (v == 0) begin
         p.m0 = '0; p.idx = '0; p.e = 1'b1; p.addr = addr; p.op = op;
         exp_q.push_back(p);
      end else begin
         for (int i = 0; i < (v + 63) / 64; i++) begin
            p.m0   = model_m0(wd[i], wv0[i], vm, v, i);
            p.idx  = 10'(i);
            p.e    = (i == (v + 63) / 64 - 1);
            p.addr = addr;
            p.op   = op;
            exp_q.push_back(p);
         end
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic run_req(int vl, bit vm, bit op, logic [31:0] addr);
      int k = 0;
      while (!req_ready && k < 50) begin @(negedge clk); k++; end
      if (!req_ready) chk("req_tmo", 0, 1);
      req_valid = 1'b1; req_vl = 17'(vl); req_vm = vm; req_opSel = op; req_addr = addr;
      push_req(vl, vm, op, addr);
      @(negedge clk);
      req_valid = 1'b0;
      chk("src_latency", 64'(src_ready), 64'(vl != 0));
   endtask

   task automatic feed(int n, bit gap);
      for (int i = 0; i < n; i++) begin
         int k = 0;
         src_valid = 1'b1; src_data = wd[i]; src_v0 = wv0[i];
         while (!src_ready && k < 20) begin @(negedge clk); k++; end
         if (!src_ready) chk("src_tmo", 0, 1);
         @(negedge clk);
         if (gap && i != n - 1) begin src_valid = 1'b0; @(negedge clk); end
      end
      src_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int k = 0;
      while (!req_ready && k < 50) begin @(negedge clk); k++; end
      if (!req_ready) chk("idle_tmo", 0, 1);
   endtask

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      hs_prev <= src_valid && src_ready;
      if (rst && src_valid && src_ready) hs_cnt <= hs_cnt + 1;
      if (rst && src_ready) sr_cnt <= sr_cnt + 1;
   end

   // Scoreboard compare on every cycle out of reset.
   always @(negedge clk) begin
      if (rst) begin
         chk("rdy_excl", 64'(req_ready && src_ready), 64'd0);
         if (lag_en) chk("lag", 64'(out_valid), 64'(hs_prev));
         if (out_valid) begin
            if (exp_q.size() == 0) chk("sb_extra", 1, 0);
            else begin
               pack_t p;
               p = exp_q.pop_front();
               chk("m0", out_m0, p.m0);
               chk("idx", 64'(out_start_idx), 64'(p.idx));
               chk("end", 64'(out_end), 64'(p.e));
               chk("addr", 64'(out_addr), 64'(p.addr));
               chk("opsel", 64'(out_opSel), 64'(p.op));
            end
            last_m0   <= out_m0;
            last_idx  <= out_start_idx;
            last_addr <= out_addr;
            if (out_end) last_end_cyc <= cyc;
         end else begin
            chk("idle_zero", out_m0 | 64'(out_addr) | 64'(out_start_idx) | 64'(out_end) | 64'(out_opSel), 64'd0);
         end
      end
   end

   initial begin
      int base_hs, base_sr, dly;
      for (int i = 0; i < 8; i++) begin wd[i] = '1; wv0[i] = '0; end

      // Pin the reference model with hand-computed values.
      chk("pin_tail70", model_m0('1, '0, 1'b1, 70, 1), 64'h3F);
      chk("pin_v0", model_m0(64'hFFFF_0000_FFFF_0000, 64'h00FF_00FF_00FF_00FF, 1'b0, 64, 0), 64'h00FF_0000_00FF_0000);
      chk("pin_full", model_m0('1, '0, 1'b1, 128, 1), 64'hFFFF_FFFF_FFFF_FFFF);

      @(negedge clk);
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      chk("rst_src_ready", 64'(src_ready), 64'd0);
      chk("rst_out", out_m0 | 64'(out_valid) | 64'(out_end) | 64'(out_addr), 64'd0);
      #2 rst = 1'b1;
      @(negedge clk);

      // vl=128 unmasked popcount; drain spacing.
      run_req(128, 1'b1, 1'b1, 32'h1000);
      feed(2, 1'b0);
      wait_idle();
      dly = cyc - last_end_cyc;
      chk("drain_gap", 64'(dly), 64'd7);

      // vl=70: tail trimmed on the second pack, two handshakes.
      base_hs = hs_cnt;
      run_req(70, 1'b1, 1'b0, 32'h2000);
      feed(2, 1'b0);
      wait_idle();
      chk("tail_m0", last_m0, 64'h3F);
      chk("hs_70", 64'(hs_cnt - base_hs), 64'd2);

      // vl=64 masked by v0.
      wd[0] = 64'hFFFF_0000_FFFF_0000; wv0[0] = 64'h00FF_00FF_00FF_00FF;
      run_req(64, 1'b0, 1'b1, 32'h3000);
      feed(1, 1'b0);
      wait_idle();
      chk("v0_m0", last_m0, 64'h00FF_0000_00FF_0000);

      // vl=0: one empty end pack, source untouched even while offered.
      base_hs = hs_cnt; base_sr = sr_cnt;
      src_valid = 1'b1; src_data = 64'h1234;
      run_req(0, 1'b1, 1'b0, 32'h40);
      wait_idle();
      src_valid = 1'b0;
      chk("zero_addr", 64'(last_addr), 64'h40);
      chk("zero_idx", 64'(last_idx), 64'd0);
      chk("zero_hs", 64'(hs_cnt - base_hs), 64'd0);
      chk("zero_srdy", 64'(sr_cnt - base_sr), 64'd0);

      // vl=192 with gaps in the source stream.
      wd[0] = 64'h0123_4567_89AB_CDEF; wd[1] = 64'hFEDC_BA98_7654_3210; wd[2] = 64'hA5A5_5A5A_F00F_0FF0;
      run_req(192, 1'b1, 1'b1, 32'h5000);
      lag_en = 1'b1;
      feed(3, 1'b1);
      wait_idle();
      lag_en = 1'b0;
      chk("gap_last_idx", 64'(last_idx), 64'd2);

      // Reset after the second of four packs.
      for (int i = 0; i < 4; i++) wd[i] = 64'hC3C3_0000_0000_0000 | 64'(i);
      run_req(256, 1'b1, 1'b0, 32'h6000);
      feed(2, 1'b0);
      #1 rst = 1'b0;
      #1;
      chk("mid_rst_out", out_m0 | 64'(out_valid) | 64'(out_end) | 64'(out_start_idx), 64'd0);
      chk("mid_rst_rdy", 64'(req_ready), 64'd1);
      chk("mid_rst_srdy", 64'(src_ready), 64'd0);
      exp_q.delete();
      @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);

      // Normal request after the abort.
      wd[0] = 64'hDEAD_BEEF_CAFE_F00D; wv0[0] = 64'h0F0F_0F0F_FFFF_0000;
      run_req(64, 1'b0, 1'b1, 32'h7000);
      feed(1, 1'b0);
      wait_idle();
      chk("post_rst_m0", last_m0, 64'h0E0D_0E0F_CAFE_0000);
      chk("sb_empty", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/vmask_pack_seq.md
Name: vmask_pack_seq

Overview:
Upstream feeder for the vector mask first-set/popcount stage. Accepts one mask-reduction request (vl, vm, opSel, destination address), pulls the vs2 and v0 mask words from the register-file read stream with a ready/valid handshake, and emits one registered pack per cycle. Before issue, each pack is ANDed with v0 when masked and has its tail bits beyond vl cleared. Enforces a drain gap after the last pack so the downstream 5-stage accumulator clears before the next request.

Parameters:
REQ_DATA_WIDTH, 64, pack width in bits (W)
REQ_ADDR_WIDTH, 32, destination address width
IDX_BITS, 10, pack index width
DATA_WIDTH_BITS, 6, log2(W)
VL_BITS, 17, request vl width
DRAIN_CYCLES, 6, idle cycles after the last pack before a new request is accepted

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
req_valid  in  1  request valid
req_ready  out  1  request accepted when high with req_valid
req_vl  in  VL_BITS  element count
req_vm  in  1  1 = unmasked, 0 = AND with v0
req_opSel  in  1  0 = first-set, 1 = popcount
req_addr  in  REQ_ADDR_WIDTH  result destination
src_valid  in  1  mask word valid
src_ready  out  1  mask word consumed
src_data  in  REQ_DATA_WIDTH  vs2 mask word
src_v0  in  REQ_DATA_WIDTH  v0 mask word, same pack index
out_valid  out  1  pack valid
out_m0  out  REQ_DATA_WIDTH  processed pack
out_start_idx  out  IDX_BITS  pack index, unshifted
out_end  out  1  last pack of request
out_addr  out  REQ_ADDR_WIDTH  latched req_addr
out_opSel  out  1  latched req_opSel

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0 except req_ready=1. Pack counter and drain counter 0. Reset mid-request aborts it with no end pack.
- States: IDLE, ISSUE, ZERO, DRAIN.
- IDLE: req_ready=1, src_ready=0. On req_valid, latch vl, vm, opSel, addr. Go to ZERO if vl==0, else ISSUE.
- vl clamp: vl > 2^(IDX_BITS+DATA_WIDTH_BITS) is treated as exactly that value.
- last_idx = ceil(vl/W)-1. tail = vl mod W. The last pack keeps bits [tail-1:0]; tail==0 keeps all W bits.
- ISSUE: src_ready=1. Each handshake at cycle c produces, at c+1:
  - out_valid=1
  - out_m0 = src_data & (vm ? all-ones : src_v0) & tailmask
  - out_start_idx = pack counter
  - out_end = (counter==last_idx)
  - out_addr and out_opSel = latched values
  The counter increments per handshake. The handshake with counter==last_idx moves to DRAIN. No handshake means out_valid=0 the next cycle, and all out_* data fields read 0 whenever out_valid=0.
- ZERO: src_ready=0. Emit one pack the next cycle with out_m0=0, out_start_idx=0, out_end=1, then go to DRAIN. No src words are consumed.
- DRAIN: req_ready=0, src_ready=0. Count DRAIN_CYCLES cycles, then go to IDLE. The first accept is DRAIN_CYCLES+1 cycles after the end pack.
- req_ready and src_ready are never both high. src words offered outside ISSUE are left untouched.
- Latency: request accepted at t gives src_ready=1 at t+1. Throughput is 1 pack/cycle.

Test Plan:
- vl=128, vm=1, opSel=1, src_data=all-ones ×2:
  - packs at idx 0 and 1, both m0=all-ones
  - end=1 on idx 1 only
  - req_ready returns 7 cycles after the end pack
- vl=70, vm=1, src_data=all-ones ×2:
  - pack1 m0=0x3F, end=1
  - exactly 2 src handshakes
- vl=64, vm=0, src_data=0xFFFF_0000_FFFF_0000, src_v0=0x00FF_00FF_00FF_00FF:
  - single pack m0=0x00FF_0000_00FF_0000, end=1
- vl=0, opSel=0, addr=0x40:
  - one pack m0=0, idx=0, end=1, addr=0x40
  - src_ready never asserted
- vl=192, src_valid toggling 1,0,1,0,1:
  - out_valid follows with a 1-cycle lag
  - idx 0,1,2 in order; data fields 0 in gap cycles
- rst pulled low after pack 1 of 4:
  - outputs 0 and req_ready=1 immediately
  - a new vl=64 request then runs normally
